// File: rtl/memory_writeback_d_ram_if.sv
// Memory-stage instruction fields in, writeback / forwarding / retire counters out.
// The master side drives the memory stage; the slave side is the writeback stage.
interface memory_writeback_d_ram_if #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 16
);
    logic             stall;
    logic             flush;
    logic             mem_ld;
    logic             mem_st;
    logic             mem_ldr;
    logic             mem_str;
    logic             mem_pre;
    logic             mem_inc;
    logic             mem_dec;
    logic [2:0]       mem_src_i;
    logic [2:0]       mem_dst_i;
    logic [WIDTH-1:0] mem_base;
    logic [WIDTH-1:0] ram_rdata;
    logic             wb_data_we;
    logic [2:0]       wb_data_idx;
    logic [WIDTH-1:0] wb_data;
    logic             wb_ptr_we;
    logic [2:0]       wb_ptr_idx;
    logic [WIDTH-1:0] wb_ptr;
    logic             fwd_valid;
    logic [2:0]       fwd_idx;
    logic [WIDTH-1:0] fwd_data;
    logic [CNT_W-1:0] ld_count;
    logic [CNT_W-1:0] st_count;

    modport master (
        output stall, flush, mem_ld, mem_st, mem_ldr, mem_str, mem_pre, mem_inc,
               mem_dec, mem_src_i, mem_dst_i, mem_base, ram_rdata,
        input  wb_data_we, wb_data_idx, wb_data, wb_ptr_we, wb_ptr_idx, wb_ptr,
               fwd_valid, fwd_idx, fwd_data, ld_count, st_count
    );

    modport slave (
        input  stall, flush, mem_ld, mem_st, mem_ldr, mem_str, mem_pre, mem_inc,
               mem_dec, mem_src_i, mem_dst_i, mem_base, ram_rdata,
        output wb_data_we, wb_data_idx, wb_data, wb_ptr_we, wb_ptr_idx, wb_ptr,
               fwd_valid, fwd_idx, fwd_data, ld_count, st_count
    );
endinterface

// File: rtl/memory_writeback_d_ram.sv
// Writeback stage after the d_ram access: one register stage, writes retire combinationally
// the next cycle; stall holds the stage and parks the load data in a hold register.
module memory_writeback_d_ram #(
    parameter int WIDTH = 16,
    parameter int STEP  = 2,
    parameter int CNT_W = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    memory_writeback_d_ram_if.slave   bus
);
    typedef enum logic { LIVE = 1'b0, HELD = 1'b1 } hold_state_t;

    hold_state_t      state;
    logic [WIDTH-1:0] hold_data;

    logic             s_valid, s_ld, s_st, s_ldr, s_str, s_inc, s_dec;
    logic [2:0]       s_src, s_dst;
    logic [WIDTH-1:0] s_base;

    logic             is_load, retire, ptr_cand, conflict;
    logic [2:0]       ptr_idx;
    logic [WIDTH-1:0] load_val, ptr_val;

    // Pre and post addressing produce the same new pointer value here.
    logic unused_pre;
    assign unused_pre = bus.mem_pre;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_valid <= 1'b0;
            s_ld    <= 1'b0;
            s_st    <= 1'b0;
            s_ldr   <= 1'b0;
            s_str   <= 1'b0;
            s_inc   <= 1'b0;
            s_dec   <= 1'b0;
            s_src   <= '0;
            s_dst   <= '0;
            s_base  <= '0;
        end else if (!bus.stall) begin
            s_valid <= (bus.mem_ld | bus.mem_st | bus.mem_ldr | bus.mem_str) & ~bus.flush;
            s_ld    <= bus.mem_ld;
            s_st    <= bus.mem_st;
            s_ldr   <= bus.mem_ldr;
            s_str   <= bus.mem_str;
            s_inc   <= bus.mem_inc;
            s_dec   <= bus.mem_dec;
            s_src   <= bus.mem_src_i;
            s_dst   <= bus.mem_dst_i;
            s_base  <= bus.mem_base;
        end
    end

    // ram_rdata is only valid the cycle after the address, so a stalled load must keep a copy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= LIVE;
            hold_data <= '0;
        end else if (bus.stall) begin
            if (state == LIVE && s_valid && is_load) begin
                state     <= HELD;
                hold_data <= bus.ram_rdata;
            end
        end else begin
            state <= LIVE;
        end
    end

    always_comb begin
        is_load  = s_ld | s_ldr;
        retire   = s_valid & ~bus.stall;
        load_val = (state == HELD) ? hold_data : bus.ram_rdata;
        ptr_cand = (s_ld | s_st) & (s_inc ^ s_dec);
        ptr_idx  = s_ld ? s_src : s_dst;
        conflict = s_ld & (ptr_idx == s_dst);
        ptr_val  = s_inc ? s_base + WIDTH'(STEP) : s_base - WIDTH'(STEP);
    end

    always_comb begin
        bus.wb_data_we  = retire & is_load;
        bus.wb_data_idx = bus.wb_data_we ? s_dst : 3'd0;
        bus.wb_data     = bus.wb_data_we ? load_val : '0;
        bus.wb_ptr_we   = retire & ptr_cand & ~conflict;
        bus.wb_ptr_idx  = bus.wb_ptr_we ? ptr_idx : 3'd0;
        bus.wb_ptr      = bus.wb_ptr_we ? ptr_val : '0;
        bus.fwd_valid   = s_valid & is_load;
        bus.fwd_idx     = bus.fwd_valid ? s_dst : 3'd0;
        bus.fwd_data    = bus.fwd_valid ? load_val : '0;
    end

    logic [CNT_W-1:0] ld_cnt, st_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ld_cnt <= '0;
            st_cnt <= '0;
        end else if (retire) begin
            if (is_load && ld_cnt != '1)
                ld_cnt <= ld_cnt + 1'b1;
            if ((s_st | s_str) && st_cnt != '1)
                st_cnt <= st_cnt + 1'b1;
        end
    end

    assign bus.ld_count = ld_cnt;
    assign bus.st_count = st_cnt;
endmodule

// File: tb/tb_memory_writeback_d_ram.sv
// Directed bench for memory_writeback_d_ram: load/store retire, pointer math, stall hold, flush, reset.
module tb_memory_writeback_d_ram;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_assert = 0;
    int   n_fail   = 0;

    memory_writeback_d_ram_if #(.WIDTH(16), .CNT_W(16)) bus ();

    memory_writeback_d_ram #(.WIDTH(16), .STEP(2), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.flush     = 1'b0;
        bus.mem_ld    = 1'b0;
        bus.mem_st    = 1'b0;
        bus.mem_ldr   = 1'b0;
        bus.mem_str   = 1'b0;
        bus.mem_pre   = 1'b0;
        bus.mem_inc   = 1'b0;
        bus.mem_dec   = 1'b0;
        bus.mem_src_i = 3'd0;
        bus.mem_dst_i = 3'd0;
        bus.mem_base  = 16'h0000;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic ld, input logic st, input logic ldr, input logic pre,
                         input logic inc, input logic dec, input logic [2:0] src,
                         input logic [2:0] dst, input logic [15:0] base);
        idle();
        bus.mem_ld    = ld;
        bus.mem_st    = st;
        bus.mem_ldr   = ldr;
        bus.mem_pre   = pre;
        bus.mem_inc   = inc;
        bus.mem_dec   = dec;
        bus.mem_src_i = src;
        bus.mem_dst_i = dst;
        bus.mem_base  = base;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_data_we"}, 32'(bus.wb_data_we), 32'd0);
        check({tag, "_ptr_we"},  32'(bus.wb_ptr_we),  32'd0);
    endtask

    initial begin
        idle();
        bus.stall     = 1'b0;
        bus.ram_rdata = 16'h0000;

        // reset state
        #12;
        check("rst_data_we", 32'(bus.wb_data_we), 32'd0);
        check("rst_fwd_valid", 32'(bus.fwd_valid), 32'd0);
        check("rst_ld_count", 32'(bus.ld_count), 32'd0);
        check("rst_st_count", 32'(bus.st_count), 32'd0);
        tick();
        rst = 1'b0;
        check_quiet("post_rst");

        // LD r1 via r2, post-inc
        issue(1, 0, 0, 0, 1, 0, 3'd2, 3'd1, 16'h1000);
        tick();
        idle();
        bus.ram_rdata = 16'hBEEF;
        @(negedge clk);
        check("ld_data_we", 32'(bus.wb_data_we), 32'd1);
        check("ld_data_idx", 32'(bus.wb_data_idx), 32'd1);
        check("ld_data", 32'(bus.wb_data), 32'hBEEF);
        check("ld_ptr_we", 32'(bus.wb_ptr_we), 32'd1);
        check("ld_ptr_idx", 32'(bus.wb_ptr_idx), 32'd2);
        check("ld_ptr", 32'(bus.wb_ptr), 32'h1002);
        check("ld_fwd_valid", 32'(bus.fwd_valid), 32'd1);
        check("ld_fwd_data", 32'(bus.fwd_data), 32'hBEEF);
        check("ld_count_pre", 32'(bus.ld_count), 32'd0);
        tick();
        check("ld_count_1", 32'(bus.ld_count), 32'd1);
        check_quiet("ld_after");

        // ST via r3, pre-dec wraps below zero
        issue(0, 1, 0, 1, 0, 1, 3'd0, 3'd3, 16'h0000);
        tick();
        idle();
        @(negedge clk);
        check("st_data_we", 32'(bus.wb_data_we), 32'd0);
        check("st_ptr_we", 32'(bus.wb_ptr_we), 32'd1);
        check("st_ptr_idx", 32'(bus.wb_ptr_idx), 32'd3);
        check("st_ptr", 32'(bus.wb_ptr), 32'hFFFE);
        check("st_fwd_valid", 32'(bus.fwd_valid), 32'd0);
        tick();
        check("st_count_1", 32'(bus.st_count), 32'd1);
        check("st_ld_count", 32'(bus.ld_count), 32'd1);

        // LD r4 via r4: load data wins, no pointer write
        issue(1, 0, 0, 0, 1, 0, 3'd4, 3'd4, 16'h0100);
        tick();
        idle();
        bus.ram_rdata = 16'h1234;
        @(negedge clk);
        check("conf_data_we", 32'(bus.wb_data_we), 32'd1);
        check("conf_data", 32'(bus.wb_data), 32'h1234);
        check("conf_ptr_we", 32'(bus.wb_ptr_we), 32'd0);
        tick();
        check("conf_ld_count", 32'(bus.ld_count), 32'd2);

        // LD r5 via r6 post-dec, stalled for 3 cycles with ram data changing
        issue(1, 0, 0, 0, 0, 1, 3'd6, 3'd5, 16'h2000);
        tick();
        idle();
        bus.stall     = 1'b1;
        bus.ram_rdata = 16'hAAAA;
        @(negedge clk);
        check_quiet("stall0");
        check("stall0_fwd_valid", 32'(bus.fwd_valid), 32'd1);
        check("stall0_fwd_data", 32'(bus.fwd_data), 32'hAAAA);
        tick();
        bus.ram_rdata = 16'h5555;
        @(negedge clk);
        check_quiet("stall1");
        check("stall1_fwd_data", 32'(bus.fwd_data), 32'hAAAA);
        check("stall1_fwd_idx", 32'(bus.fwd_idx), 32'd5);
        tick();
        check_quiet("stall2");
        check("stall2_fwd_data", 32'(bus.fwd_data), 32'hAAAA);
        tick();
        bus.stall = 1'b0;
        @(negedge clk);
        check("rel_data_we", 32'(bus.wb_data_we), 32'd1);
        check("rel_data", 32'(bus.wb_data), 32'hAAAA);
        check("rel_ptr_we", 32'(bus.wb_ptr_we), 32'd1);
        check("rel_ptr", 32'(bus.wb_ptr), 32'h1FFE);
        check("rel_ld_count_pre", 32'(bus.ld_count), 32'd2);
        tick();
        check("rel_ld_count", 32'(bus.ld_count), 32'd3);
        check_quiet("rel_after");

        // LDR squashed by flush
        issue(0, 0, 1, 0, 0, 0, 3'd1, 3'd7, 16'h3000);
        bus.flush = 1'b1;
        tick();
        idle();
        @(negedge clk);
        check_quiet("flush");
        check("flush_fwd_valid", 32'(bus.fwd_valid), 32'd0);
        tick();
        check("flush_ld_count", 32'(bus.ld_count), 32'd3);
        check("flush_st_count", 32'(bus.st_count), 32'd1);

        // async reset while a held load is parked
        issue(1, 0, 0, 0, 1, 0, 3'd2, 3'd3, 16'h4000);
        tick();
        idle();
        bus.stall     = 1'b1;
        bus.ram_rdata = 16'h7777;
        tick();
        check("held_fwd_data", 32'(bus.fwd_data), 32'h7777);
        #2;
        rst = 1'b1;
        #1;
        check("arst_fwd_valid", 32'(bus.fwd_valid), 32'd0);
        check("arst_fwd_data", 32'(bus.fwd_data), 32'd0);
        check("arst_ld_count", 32'(bus.ld_count), 32'd0);
        check("arst_st_count", 32'(bus.st_count), 32'd0);
        bus.stall = 1'b0;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check_quiet("arst_rel");
        check("arst_rel_fwd_valid", 32'(bus.fwd_valid), 32'd0);
        tick();
        check("arst_rel_ld_count", 32'(bus.ld_count), 32'd0);
        check("arst_rel_st_count", 32'(bus.st_count), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
